id_scoreboard: RTL and testbench

- Issue-control scoreboard between the decode stage and execute.
- Tracks which GPRs (x1..x31) have an in-flight write pending. Stalls decode on RAW/WAW hazards or when the outstanding-write limit is reached.
- Frees entries on writeback; whole table can be flushed.
- Single clock domain; sits beside the decode stage and consumes its register-enable/address outputs.

---
 rtl/id_scoreboard_pkg.sv | 8 +
 rtl/scb_busy_table.sv | 23 ++
 rtl/id_scoreboard.sv | 69 ++++++
 tb/tb_id_scoreboard.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/id_scoreboard_pkg.sv
// id_scoreboard_pkg: shared register-file geometry and helpers for the issue scoreboard
package id_scoreboard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM = 32;
  function automatic logic [REG_NUM-1:0] onehot(input logic [REG_ADDR_W-1:0] a);
    return REG_NUM'(1) << a;
  endfunction
endpackage

// File: rtl/scb_busy_table.sv
// scb_busy_table: per-GPR pending-write bits, set wins over clear, x0 hard-wired to zero
module scb_busy_table import id_scoreboard_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [REG_NUM-1:0]    mask,
  output logic                  clr_hit
);
  logic [REG_NUM-1:0] set_vec, clr_vec;
  always_comb begin
    set_vec = set_en ? onehot(set_addr) : '0;
    clr_vec = clr_en ? onehot(clr_addr) : '0;
    clr_hit = clr_en && clr_addr != '0 && mask[clr_addr];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) mask <= '0;
    else mask <= ((mask & ~clr_vec) | set_vec) & ~REG_NUM'(1);
  end
endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: decode-stage RAW/WAW/capacity stall control with writeback release.
// Define SCB_WB_BYPASS_EN to let a same-cycle writeback resolve hazards.
module id_scoreboard import id_scoreboard_pkg::*; #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic                   rs1_r_ena,
  input  logic [REG_ADDR_W-1:0]  rs1_r_addr,
  input  logic                   rs2_r_ena,
  input  logic [REG_ADDR_W-1:0]  rs2_r_addr,
  input  logic                   rd_w_ena,
  input  logic [REG_ADDR_W-1:0]  rd_w_addr,
  output logic                   issue,
  input  logic                   wb_valid,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic                   flush,
  output logic [REG_NUM-1:0]     busy_mask,
  output logic [CNT_W-1:0]       outstanding,
  output logic                   sb_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  logic [REG_NUM-1:0] busy_eff;
  logic wr, raw1, raw2, waw, full, set_en, clr_hit;
  always_comb begin
`ifdef SCB_WB_BYPASS_EN
    busy_eff = busy_mask & ~(wb_valid ? onehot(wb_addr) : '0);
`else
    busy_eff = busy_mask;
`endif
    wr = rd_w_ena && rd_w_addr != '0;
    raw1 = rs1_r_ena && busy_eff[rs1_r_addr];
    raw2 = rs2_r_ena && busy_eff[rs2_r_addr];
    waw = wr && busy_eff[rd_w_addr];
    full = outstanding == CNT_W'(MAX_OUTSTANDING) && wr;
    id_ready = !rst && !flush && !(raw1 || raw2 || waw || full);
    issue = id_valid && id_ready;
    set_en = issue && wr;
  end
  scb_busy_table u_busy (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .set_en(set_en),
    .set_addr(rd_w_addr),
    .clr_en(wb_valid && !flush),
    .clr_addr(wb_addr),
    .mask(busy_mask),
    .clr_hit(clr_hit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      sb_err <= 1'b0;
      stall_cycles <= '0;
    end else begin
      if (id_valid && !id_ready && stall_cycles != '1) stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      if (flush) outstanding <= '0;
      else begin
        outstanding <= outstanding + CNT_W'(set_en) - CNT_W'(clr_hit);
        if (wb_valid && !clr_hit) sb_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_id_scoreboard.sv
// tb_id_scoreboard: directed and random stimulus against a set-based scoreboard model
module tb_id_scoreboard;
  localparam int MAXO = 4;
  localparam int SW = 6;
  logic clk = 0, rst = 1, id_valid = 0, id_ready, rs1_r_ena = 0, rs2_r_ena = 0, rd_w_ena = 0;
  logic [4:0] rs1_r_addr = 0, rs2_r_addr = 0, rd_w_addr = 0, wb_addr = 0;
  logic issue, wb_valid = 0, flush = 0, sb_err;
  logic [31:0] busy_mask;
  logic [2:0] outstanding;
  logic [SW-1:0] stall_cycles;
  int total = 0, bad = 0;
  bit [31:0] m_busy = 0;
  int m_stall = 0;
  bit m_err = 0;

  id_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(3), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr), .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr), .issue(issue), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush), .busy_mask(busy_mask), .outstanding(outstanding), .sb_err(sb_err),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit beff(input logic [4:0] a);
    bit b;
    b = m_busy[a];
`ifdef SCB_WB_BYPASS_EN
    if (wb_valid && wb_addr == a) b = 0;
`endif
    return b;
  endfunction

  always @(negedge clk) begin
    bit wr, hz, rdy, hit;
    wr = rd_w_ena && rd_w_addr != 0;
    hz = (rs1_r_ena && beff(rs1_r_addr)) || (rs2_r_ena && beff(rs2_r_addr)) ||
         (wr && beff(rd_w_addr)) || (wr && $countones(m_busy) == MAXO);
    rdy = !rst && !flush && !hz;
    chk("id_ready", 32'(id_ready), 32'(rdy));
    chk("issue", 32'(issue), 32'(rdy && id_valid));
    chk("busy_mask", busy_mask, m_busy);
    chk("outstanding", 32'(outstanding), 32'($countones(m_busy)));
    chk("sb_err", 32'(sb_err), 32'(m_err));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    if (rst) begin
      m_busy = 0; m_err = 0; m_stall = 0;
    end else begin
      if (id_valid && !rdy && m_stall < (1 << SW) - 1) m_stall++;
      if (flush) m_busy = 0;
      else begin
        hit = wb_valid && wb_addr != 0 && m_busy[wb_addr];
        if (wb_valid && !hit) m_err = 1;
        if (hit) m_busy[wb_addr] = 0;
        if (rdy && id_valid && wr) m_busy[rd_w_addr] = 1;
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
    {rst, id_valid, rs1_r_ena, rs2_r_ena, rd_w_ena, wb_valid, flush} = '0;
    {rs1_r_addr, rs2_r_addr, rd_w_addr, wb_addr} = '0;
  endtask

  task automatic wr_op(input logic [4:0] rd);
    id_valid = 1; rd_w_ena = 1; rd_w_addr = rd;
  endtask

  task automatic rd_op(input logic [4:0] rs);
    id_valid = 1; rs1_r_ena = 1; rs1_r_addr = rs;
  endtask

  initial begin
    rst = 1; id_valid = 1;
    repeat (3) @(posedge clk);
    #1 chk("rst_ready", 32'(id_ready), 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_out", 32'(outstanding), 0);
    chk("rst_stall", 32'(stall_cycles), 0);
    go(); rst = 0;
    go(); wr_op(5); #1 chk("issue_x5", 32'(issue), 1);
    go(); rd_op(5); #1 chk("raw_ready", 32'(id_ready), 0);
    chk("busy_x5", busy_mask, 32'h20);
    go(); rd_op(5); #1 chk("stall_1", 32'(stall_cycles), 1);
    go(); rd_op(5); wb_valid = 1; wb_addr = 5;
`ifdef SCB_WB_BYPASS_EN
    #1 chk("bypass_issue", 32'(issue), 1);
`else
    #1 chk("wb_cycle_issue", 32'(issue), 0);
`endif
    go(); rd_op(5); #1 chk("after_wb_issue", 32'(issue), 1);
    chk("after_wb_busy", busy_mask, 0);
    go(); wr_op(0); #1 chk("x0_wr_issue", 32'(issue), 1);
    go(); rd_op(0); #1 chk("x0_rd_issue", 32'(issue), 1);
    chk("x0_busy", busy_mask, 0);
    chk("x0_out", 32'(outstanding), 0);
    for (int i = 1; i <= 4; i++) begin
      go(); wr_op(5'(i));
    end
    go(); wr_op(6); #1 chk("full_out", 32'(outstanding), 4);
    chk("full_ready", 32'(id_ready), 0);
    chk("full_busy", busy_mask, 32'h1E);
    go(); rd_op(7); #1 chk("read_while_full", 32'(issue), 1);
    go(); wr_op(6); wb_valid = 1; wb_addr = 2; #1 chk("full_wb_cycle", 32'(issue), 0);
    go(); wr_op(6); #1 chk("x6_issue", 32'(issue), 1);
    go(); #1 chk("cap_out", 32'(outstanding), 4);
    chk("cap_busy", busy_mask, 32'h5A);
    go(); wr_op(8); flush = 1; #1 chk("flush_issue", 32'(issue), 0);
    go(); #1 chk("flush_busy", busy_mask, 0);
    chk("flush_out", 32'(outstanding), 0);
    go(); wb_valid = 1; wb_addr = 9;
    go(); #1 chk("err_set", 32'(sb_err), 1);
    chk("err_out", 32'(outstanding), 0);
    go(); wr_op(10);
    go(); wr_op(10); wb_valid = 1; wb_addr = 10;
`ifdef SCB_WB_BYPASS_EN
    #1 chk("set_wins_issue", 32'(issue), 1);
`else
    #1 chk("waw_stall", 32'(issue), 0);
`endif
    go(); #1 chk("x10_busy", busy_mask,
`ifdef SCB_WB_BYPASS_EN
      32'h400
`else
      32'h0
`endif
    );
    chk("err_sticky", 32'(sb_err), 1);
    go(); wr_op(11);
    for (int i = 0; i < 70; i++) begin
      go(); id_valid = 1; rs2_r_ena = 1; rs2_r_addr = 11;
    end
    go(); #1 chk("stall_sat", 32'(stall_cycles), 63);
    for (int i = 0; i < 300; i++) begin
      go();
      rst = $urandom_range(0, 59) == 0;
      flush = $urandom_range(0, 29) == 0;
      id_valid = 1'($urandom);
      rs1_r_ena = 1'($urandom); rs1_r_addr = 5'($urandom_range(0, 7));
      rs2_r_ena = 1'($urandom); rs2_r_addr = 5'($urandom_range(0, 7));
      rd_w_ena = 1'($urandom); rd_w_addr = 5'($urandom_range(0, 7));
      wb_valid = 1'($urandom); wb_addr = 5'($urandom_range(0, 7));
    end
    go(); rst = 1;
    go(); #1 chk("final_err", 32'(sb_err), 0);
    go();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
